// File: rtl/sta_pipe_pkg.sv
// ---------------------------------------------------------------------------
// sta_pipe_pkg
// Shared backend definitions for the store-address pipeline and the other
// squash consumers:
//   - datapath widths (XLEN, PADDR_W, ROB_W, SQ_W) and paddr_t
//   - store exception cause codes
//   - sta_uop_t, the store-address uop carried through s0/s1 and the slot
//   - slot_state_t, the replay slot FSM encoding
//   - robIdx_younger(): wrap-flag aware ROB age compare
//   - isMisaligned(): natural alignment check for B/H/W/D accesses
// ---------------------------------------------------------------------------
package sta_pipe_pkg;

  localparam int XLEN    = 64;
  localparam int PADDR_W = 39;
  localparam int ROB_W   = 7;
  localparam int SQ_W    = 5;

  typedef logic [PADDR_W-1:0] paddr_t;

  localparam logic [4:0] EXC_SAM = 5'd6;
  localparam logic [4:0] EXC_SAF = 5'd7;
  localparam logic [4:0] EXC_SPF = 5'd15;

  typedef struct packed {
    logic [XLEN-1:0]  vaddr;
    logic [1:0]       size;
    logic [ROB_W:0]   robIdx;
    logic [SQ_W-1:0]  sqIdx;
    logic             misalign;
  } sta_uop_t;

  typedef enum logic [1:0] {
    SLOT_IDLE    = 2'd0,
    SLOT_WAIT    = 2'd1,
    SLOT_REISSUE = 2'd2
  } slot_state_t;

  // True when a is strictly younger than b. The MSB is a wrap flag that
  // toggles each time the ROB pointer wraps, so with differing flags the
  // numerically smaller index is the younger one. Equal indices are not
  // younger.
  function automatic logic robIdx_younger(input logic [ROB_W:0] a,
                                          input logic [ROB_W:0] b);
    logic res;
    if (a[ROB_W] == b[ROB_W]) res = (a[ROB_W-1:0] > b[ROB_W-1:0]);
    else                      res = (a[ROB_W-1:0] < b[ROB_W-1:0]);
    return res;
  endfunction

  function automatic logic isMisaligned(input logic [2:0] lowBits,
                                        input logic [1:0] size);
    logic res;
    case (size)
      2'd1:    res = lowBits[0];
      2'd2:    res = |lowBits[1:0];
      2'd3:    res = |lowBits;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sta_replay_slot.sv
// ---------------------------------------------------------------------------
// sta_replay_slot
// Holds one TLB-missed store-address uop, waits REPLAY_WAIT cycles and then
// asks the pipe to reinject it into s0 for exactly one cycle.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_capVld/i_capUop capture request for a missed uop (honoured only when
//                     o_canCapture is high)
//   i_squashVld/i_squashRobIdx  squash; a younger held uop is dropped
//   o_canCapture      slot is IDLE or leaving REISSUE this cycle
//   o_reissueVld      slot is in REISSUE, o_uop must be injected into s0
//   o_uop             the held uop
// ---------------------------------------------------------------------------
module sta_replay_slot
  import sta_pipe_pkg::*;
#(
  parameter int REPLAY_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_capVld,
  input  sta_uop_t        i_capUop,
  input  logic            i_squashVld,
  input  logic [ROB_W:0]  i_squashRobIdx,
  output logic            o_canCapture,
  output logic            o_reissueVld,
  output sta_uop_t        o_uop
);

  localparam int              CNT_W    = (REPLAY_WAIT > 1) ? $clog2(REPLAY_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REPLAY_WAIT - 1);

  slot_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  sta_uop_t         r_uop;
  logic             w_kill;

  assign w_kill = (r_state != SLOT_IDLE) && i_squashVld &&
                  robIdx_younger(r_uop.robIdx, i_squashRobIdx);

  // REISSUE always lasts one cycle, so a new capture may overwrite the slot
  // while it is leaving REISSUE; the reissued copy is already on its way
  // through s0.
  assign o_canCapture = (r_state != SLOT_WAIT);
  assign o_reissueVld = (r_state == SLOT_REISSUE);
  assign o_uop        = r_uop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SLOT_IDLE;
      r_cnt   <= '0;
      r_uop   <= '0;
    end else if (i_capVld && o_canCapture) begin
      r_state <= SLOT_WAIT;
      r_cnt   <= CNT_LOAD;
      r_uop   <= i_capUop;
    end else begin
      unique case (r_state)
        SLOT_IDLE: r_state <= SLOT_IDLE;
        SLOT_WAIT: begin
          if (w_kill)             r_state <= SLOT_IDLE;
          else if (r_cnt == '0)   r_state <= SLOT_REISSUE;
          else                    r_cnt   <= r_cnt - 1'b1;
        end
        SLOT_REISSUE: r_state <= SLOT_IDLE;
        default:      r_state <= SLOT_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sta_pipe.sv
// ---------------------------------------------------------------------------
// sta_pipe
// Store-address pipeline between the store issue queue and the store queue.
//   s0: vaddr = base + sext(imm), alignment check, dTLB request
//   s1: dTLB result resolved (misalign > miss > illegaAddr > pagefault)
//   s2: registered SQ address write, exception, or external replay
// TLB misses park in a one-entry replay slot and are reinjected into s0
// with priority over new issue; if the slot is busy the miss is bounced
// back to the issue queue via o_replay_*.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_squash_vld/_robIdx      kill all uops strictly younger than robIdx
//   i_iss_* / o_iss_rdy       issue handshake and uop fields
//   o_mmu_s0_*                dTLB lookup request
//   i_mmu_s1_*                dTLB result, one cycle after the request
//   o_sq_*                    store queue address write (s2)
//   o_exc_*                   store exception report (s2)
//   o_replay_*                replay request to the issue queue (s2)
// ---------------------------------------------------------------------------
module sta_pipe
  import sta_pipe_pkg::*;
#(
  parameter int REPLAY_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_squash_vld,
  input  logic [ROB_W:0]      i_squash_robIdx,
  input  logic                i_iss_vld,
  output logic                o_iss_rdy,
  input  logic [XLEN-1:0]     i_iss_base,
  input  logic [11:0]         i_iss_imm,
  input  logic [1:0]          i_iss_size,
  input  logic [ROB_W:0]      i_iss_robIdx,
  input  logic [SQ_W-1:0]     i_iss_sqIdx,
  output logic                o_mmu_s0_req,
  output logic [XLEN-1:0]     o_mmu_s0_vaddr,
  input  logic                i_mmu_s1_miss,
  input  logic                i_mmu_s1_pagefault,
  input  logic                i_mmu_s1_illegaAddr,
  input  logic                i_mmu_s1_mmio,
  input  logic [PADDR_W-1:0]  i_mmu_s1_paddr,
  output logic                o_sq_wr_vld,
  output logic [SQ_W-1:0]     o_sq_sqIdx,
  output logic [XLEN-1:0]     o_sq_vaddr,
  output logic [PADDR_W-1:0]  o_sq_paddr,
  output logic                o_sq_mmio,
  output logic [1:0]          o_sq_size,
  output logic                o_exc_vld,
  output logic [ROB_W:0]      o_exc_robIdx,
  output logic [4:0]          o_exc_cause,
  output logic [XLEN-1:0]     o_exc_tval,
  output logic                o_replay_vld,
  output logic [ROB_W:0]      o_replay_robIdx,
  output logic [SQ_W-1:0]     o_replay_sqIdx
);

  // s0 signals
  logic [XLEN-1:0] w_issVaddr;
  sta_uop_t        w_issUop;
  sta_uop_t        w_s0Uop;
  logic            w_s0Vld;
  logic            w_s0Kill;

  // replay slot signals
  sta_uop_t        w_slotUop;
  logic            w_slotReissue;
  logic            w_slotCanCapture;
  logic            w_capVld;

  // s1 registers and resolution
  logic            r_s1Vld;
  sta_uop_t        r_s1Uop;
  logic            w_s1Live;
  logic            w_s1Exc;
  logic            w_s1Miss;
  logic            w_s1Norm;
  logic [4:0]      w_s1Cause;
  logic            w_extReplay;

  // ---------------- s0 ----------------
  assign w_issVaddr = i_iss_base + {{(XLEN-12){i_iss_imm[11]}}, i_iss_imm};

  always_comb begin
    w_issUop          = '0;
    w_issUop.vaddr    = w_issVaddr;
    w_issUop.size     = i_iss_size;
    w_issUop.robIdx   = i_iss_robIdx;
    w_issUop.sqIdx    = i_iss_sqIdx;
    w_issUop.misalign = isMisaligned(w_issVaddr[2:0], i_iss_size);
  end

  // The slot's reissue owns s0 for its one REISSUE cycle; new issue is
  // refused that cycle through o_iss_rdy.
  assign o_iss_rdy      = !w_slotReissue;
  assign w_s0Uop        = w_slotReissue ? w_slotUop : w_issUop;
  assign w_s0Vld        = w_slotReissue || (i_iss_vld && o_iss_rdy);
  assign w_s0Kill       = i_squash_vld && robIdx_younger(w_s0Uop.robIdx, i_squash_robIdx);
  assign o_mmu_s0_req   = w_s0Vld && !w_s0Uop.misalign && !w_s0Kill;
  assign o_mmu_s0_vaddr = w_s0Uop.vaddr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Vld <= 1'b0;
      r_s1Uop <= '0;
    end else begin
      r_s1Vld <= w_s0Vld && !w_s0Kill;
      r_s1Uop <= w_s0Uop;
    end
  end

  // ---------------- s1 ----------------
  // A misaligned uop never sent a TLB request, so its MMU flags are
  // meaningless and it must win over everything, including miss.
  assign w_s1Live = r_s1Vld &&
                    !(i_squash_vld && robIdx_younger(r_s1Uop.robIdx, i_squash_robIdx));
  assign w_s1Miss = w_s1Live && !r_s1Uop.misalign && i_mmu_s1_miss;
  assign w_s1Exc  = w_s1Live && (r_s1Uop.misalign ||
                    (!i_mmu_s1_miss && (i_mmu_s1_illegaAddr || i_mmu_s1_pagefault)));
  assign w_s1Norm = w_s1Live && !r_s1Uop.misalign && !i_mmu_s1_miss &&
                    !i_mmu_s1_illegaAddr && !i_mmu_s1_pagefault;

  always_comb begin
    w_s1Cause = EXC_SPF;
    if (r_s1Uop.misalign)         w_s1Cause = EXC_SAM;
    else if (i_mmu_s1_illegaAddr) w_s1Cause = EXC_SAF;
  end

  assign w_capVld    = w_s1Miss && w_slotCanCapture;
  assign w_extReplay = w_s1Miss && !w_slotCanCapture;

  // ---------------- s2 (registered outputs) ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      o_sq_wr_vld     <= 1'b0;
      o_sq_sqIdx      <= '0;
      o_sq_vaddr      <= '0;
      o_sq_paddr      <= '0;
      o_sq_mmio       <= 1'b0;
      o_sq_size       <= '0;
      o_exc_vld       <= 1'b0;
      o_exc_robIdx    <= '0;
      o_exc_cause     <= '0;
      o_exc_tval      <= '0;
      o_replay_vld    <= 1'b0;
      o_replay_robIdx <= '0;
      o_replay_sqIdx  <= '0;
    end else begin
      o_sq_wr_vld  <= w_s1Norm;
      o_exc_vld    <= w_s1Exc;
      o_replay_vld <= w_extReplay;
      if (w_s1Norm) begin
        o_sq_sqIdx <= r_s1Uop.sqIdx;
        o_sq_vaddr <= r_s1Uop.vaddr;
        o_sq_paddr <= i_mmu_s1_paddr;
        o_sq_mmio  <= i_mmu_s1_mmio;
        o_sq_size  <= r_s1Uop.size;
      end
      if (w_s1Exc) begin
        o_exc_robIdx <= r_s1Uop.robIdx;
        o_exc_cause  <= w_s1Cause;
        o_exc_tval   <= r_s1Uop.vaddr;
      end
      if (w_extReplay) begin
        o_replay_robIdx <= r_s1Uop.robIdx;
        o_replay_sqIdx  <= r_s1Uop.sqIdx;
      end
    end
  end

  // ---------------- replay slot ----------------
  sta_replay_slot #(
    .REPLAY_WAIT (REPLAY_WAIT)
  ) u_replaySlot (
    .clk            (clk),
    .rst            (rst),
    .i_capVld       (w_capVld),
    .i_capUop       (r_s1Uop),
    .i_squashVld    (i_squash_vld),
    .i_squashRobIdx (i_squash_robIdx),
    .o_canCapture   (w_slotCanCapture),
    .o_reissueVld   (w_slotReissue),
    .o_uop          (w_slotUop)
  );

endmodule
